// File: rtl/register_scoreboard_pkg.sv
// Shared core constants for the register scoreboard.
// Register file geometry and default pending-write capacity.
package register_scoreboard_pkg;

    localparam int NUM_REGS           = 32;
    localparam int REG_ADDR_W         = 5;
    localparam int SB_MAX_OUTSTANDING = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    // One-hot select of a register; x0 never selected.
    function automatic reg_vec_t reg_onehot(input logic en, input reg_addr_t a);
        reg_vec_t v;
        v = '0;
        if (en && a != '0) v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Busy-bit scoreboard for in-flight long-latency register writes.
// Raises a stall to ID on RAW/WAW hazards against pending results or when full.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = SB_MAX_OUTSTANDING,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  reg_write_id,
    input  logic                  long_op_id,
    input  logic                  issue_id,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    input  logic                  cmpl_valid,
    input  logic [REG_ADDR_W-1:0] cmpl_rd,
    output logic                  stall_id,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [CNT_W-1:0]      outstanding
);

    reg_vec_t         busy_q;
    reg_vec_t         busy_d;
    reg_vec_t         cmpl_mask;
    reg_vec_t         kill_mask;
    reg_vec_t         set_mask;
    reg_vec_t         eff_busy;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_no_issue;
    logic             clr_cmpl;
    logic             clr_kill;
    logic             set_en;
    logic             full;

    // Clear/set decode and hazard evaluation against bypassed busy state.
    always_comb begin
        cmpl_mask = reg_onehot(cmpl_valid, cmpl_rd);
        kill_mask = reg_onehot(kill_valid, kill_rd);
        // Clears only count when they hit a pending entry; a kill that
        // duplicates the completion register is not counted twice.
        clr_cmpl = |(cmpl_mask & busy_q);
        clr_kill = |(kill_mask & busy_q) && !(clr_cmpl && kill_rd == cmpl_rd);
        eff_busy = busy_q & ~cmpl_mask & ~kill_mask;
        cnt_no_issue = cnt_q - CNT_W'(clr_cmpl) - CNT_W'(clr_kill);
        full = long_op_id && reg_write_id
            && cnt_no_issue == CNT_W'(MAX_OUTSTANDING);
        stall_id = eff_busy[rs1_id] || eff_busy[rs2_id]
            || (reg_write_id && eff_busy[rd_id]) || full;
        set_en = issue_id && reg_write_id && long_op_id && rd_id != '0;
        set_mask = reg_onehot(set_en, rd_id);
        busy_d = eff_busy | set_mask;
        busy_d[0] = 1'b0;
        cnt_d = cnt_no_issue + CNT_W'(set_en);
    end

    // Busy bits and pending counter; reset drops every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Completion and kill never target the same register together.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(cmpl_valid && kill_valid && cmpl_rd == kill_rd
                      && cmpl_rd != '0));
        end
    end

    assign busy_vec    = busy_q;
    assign outstanding = cnt_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard.
// Directed scenarios followed by random traffic against a busy-set model.
module tb_register_scoreboard;

    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_id, rs2_id, rd_id, kill_rd, cmpl_rd;
    logic          reg_write_id, long_op_id, issue_id;
    logic          kill_valid, cmpl_valid;
    logic          stall_id;
    logic [31:0]   busy_vec;
    logic [CW-1:0] outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: set of registers with a pending long-latency write.
    bit [31:0] mb;

    register_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .reg_write_id(reg_write_id), .long_op_id(long_op_id),
        .issue_id(issue_id),
        .kill_valid(kill_valid), .kill_rd(kill_rd),
        .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
        .stall_id(stall_id), .busy_vec(busy_vec),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pending set after this cycle's completion/kill are removed.
    function automatic bit [31:0] m_after_clear();
        bit [31:0] e;
        e = mb;
        if (cmpl_valid) e[cmpl_rd] = 1'b0;
        if (kill_valid) e[kill_rd] = 1'b0;
        e[0] = 1'b0;
        return e;
    endfunction

    function automatic bit m_stall();
        bit [31:0] e;
        e = m_after_clear();
        return e[rs1_id] || e[rs2_id] || (reg_write_id && e[rd_id])
            || (long_op_id && reg_write_id && $countones(e) == MAXO);
    endfunction

    task automatic idle_inputs();
        rs1_id = 0; rs2_id = 0; rd_id = 0;
        reg_write_id = 0; long_op_id = 0; issue_id = 0;
        kill_valid = 0; kill_rd = 0; cmpl_valid = 0; cmpl_rd = 0;
    endtask

    task automatic set_id(input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic w,
                          input logic l, input logic iss);
        rs1_id = a; rs2_id = b; rd_id = d;
        reg_write_id = w; long_op_id = l; issue_id = iss;
    endtask

    // Inputs already driven after a falling edge: check stall, clock, check state.
    task automatic step(input string tag);
        bit [31:0] e;
        #1;
        chk({tag, "_stall"}, 32'(stall_id), 32'(m_stall()));
        e = m_after_clear();
        if (issue_id && reg_write_id && long_op_id && rd_id != 0)
            e[rd_id] = 1'b1;
        @(posedge clk);
        mb = e;
        #1;
        chk({tag, "_busy"}, busy_vec, mb);
        chk({tag, "_cnt"}, 32'(outstanding), 32'($countones(mb)));
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        mb = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_cnt", 32'(outstanding), 32'h0);
        chk("reset_stall", 32'(stall_id), 32'h0);
        @(negedge clk);

        // DIV to x5, then a reader of x5
        set_id(1, 2, 5, 1, 1, 1);
        step("div_x5");
        chk("div_x5_const", busy_vec, 32'h0000_0020);
        set_id(5, 0, 6, 1, 0, 0);
        #1 chk("raw_x5", 32'(stall_id), 32'h1);
        cmpl_valid = 1; cmpl_rd = 5; issue_id = 1;
        #1 chk("raw_bypass", 32'(stall_id), 32'h0);
        step("cmpl_x5");
        chk("cmpl_x5_const", busy_vec, 32'h0);

        // WAW on x7
        set_id(0, 0, 7, 1, 1, 1);
        step("long_x7");
        set_id(0, 0, 7, 1, 0, 0);
        #1 chk("waw_x7", 32'(stall_id), 32'h1);
        set_id(0, 0, 8, 1, 0, 1);
        #1 chk("nowaw_x8", 32'(stall_id), 32'h0);
        step("write_x8");
        cmpl_valid = 1; cmpl_rd = 7;
        step("cmpl_x7");

        // Fill to capacity, then swap x2 for x6
        for (int r = 1; r <= 4; r++) begin
            set_id(0, 0, 5'(r), 1, 1, 1);
            step("fill");
        end
        set_id(0, 0, 6, 1, 1, 0);
        #1 chk("full_stall", 32'(stall_id), 32'h1);
        chk("full_cnt", 32'(outstanding), 32'd4);
        cmpl_valid = 1; cmpl_rd = 2; issue_id = 1;
        step("full_swap");
        chk("swap_cnt", 32'(outstanding), 32'd4);
        chk("swap_busy", busy_vec, 32'h0000_005A);

        // Drain, long op to x0, kill, spurious completion
        cmpl_valid = 1; cmpl_rd = 1; kill_valid = 1; kill_rd = 3;
        step("drain_a");
        cmpl_valid = 1; cmpl_rd = 4; kill_valid = 1; kill_rd = 6;
        step("drain_b");
        set_id(0, 0, 0, 1, 1, 1);
        step("long_x0");
        chk("x0_busy", busy_vec, 32'h0);
        set_id(0, 0, 9, 1, 1, 1);
        step("long_x9");
        kill_valid = 1; kill_rd = 9;
        step("kill_x9");
        chk("kill_x9_const", busy_vec, 32'h0);
        set_id(0, 0, 11, 1, 1, 1);
        step("long_x11");
        cmpl_valid = 1; cmpl_rd = 10;
        step("spurious_x10");
        chk("spurious_const", busy_vec, 32'h0000_0800);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
            cmpl_valid = 1'($urandom_range(0, 1));
            cmpl_rd = 5'($urandom_range(0, 7));
            kill_valid = ($urandom_range(0, 5) == 0);
            kill_rd = 5'($urandom_range(0, 7));
            if (kill_rd == cmpl_rd) kill_valid = 1'b0;
            issue_id = ($urandom_range(0, 3) != 0) && !m_stall();
            step("rand");
        end

        // Reset with three entries pending
        for (int r = 12; r <= 14; r++) begin
            set_id(0, 0, 5'(r), 1, 1, 1);
            step("pre_rst");
        end
        #2 rst_n = 1'b0;
        mb = '0;
        #1;
        chk("async_rst_busy", busy_vec, 32'h0);
        chk("async_rst_cnt", 32'(outstanding), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
